// File: rtl/plot_stream_receiver_if.sv
// Pixel plot stream from the sprite counters plus the framebuffer write port.
// The receiver uses the slave view; the sender/memory side uses the master view.
interface plot_stream_receiver_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        color;
    logic              plot;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_data;
    logic              mem_wren;
    logic              mem_ack;

    modport master (
        output x, y, color, plot, done, mem_ack,
        input  mem_addr, mem_data, mem_wren
    );

    modport slave (
        input  x, y, color, plot, done, mem_ack,
        output mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/plot_stream_receiver.sv
// Buffers plot beats, range-checks them, converts to linear framebuffer addresses
// and writes them to memory with a held wren/ack handshake; reports rectangle drain.
module plot_stream_receiver #(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 15
) (
    input  logic                   clk,
    input  logic                   resetn,
    plot_stream_receiver_if.slave  bus,
    output logic                   drain_done,
    output logic                   overflow,
    output logic [15:0]            pix_count,
    output logic [7:0]             drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]       X_LIMIT  = 32'(SCREEN_W);
    localparam logic [31:0]       Y_LIMIT  = 32'(SCREEN_H);
    localparam logic [ADDR_W-1:0] W_STRIDE = ADDR_W'(SCREEN_W);
    localparam logic [CNT_W-1:0]  C_FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_pop;

    logic [ADDR_W-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [2:0]        r_fifo_color [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [2:0]        r_mem_data;
    logic              r_done_seen;
    logic              r_drain_done;
    logic              r_overflow;
    logic [15:0]       r_pix_count;
    logic [7:0]        r_drop_count;

    logic              w_empty;
    logic              w_full;
    logic              w_in_range;
    logic              w_beat_ok;
    logic              w_push;
    logic              w_lost;
    logic              w_ack_fire;
    logic              w_drain_fire;
    logic [ADDR_W-1:0] w_pix_addr;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_FULL);
    assign w_in_range = (32'(bus.x) < X_LIMIT) && (32'(bus.y) < Y_LIMIT);
    assign w_pix_addr = ADDR_W'(bus.y) * W_STRIDE + ADDR_W'(bus.x);
    assign w_beat_ok  = bus.plot && w_in_range;
    // A full FIFO can still take a beat when the write side frees a slot this cycle.
    assign w_push     = w_beat_ok && (!w_full || w_pop);
    assign w_lost     = w_beat_ok && w_full && !w_pop;
    assign w_ack_fire = (r_state == ST_WRITE) && bus.mem_ack;

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // Drain is judged on the post-edge FIFO/FSM state so the returning-from-WRITE edge counts.
    assign w_drain_fire = r_done_seen && (w_state_next == ST_IDLE) && (w_count_next == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= w_pix_addr;
            r_fifo_color[r_wr_ptr] <= bus.color;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_mem_addr <= r_fifo_addr[r_rd_ptr];
                r_mem_data <= r_fifo_color[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pix_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
            r_done_seen  <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            if (w_ack_fire) begin
                r_pix_count <= r_pix_count + 16'd1;
            end
            if (bus.plot && !w_in_range && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            if (w_lost) begin
                r_overflow <= 1'b1;
            end
            // A done landing on the firing edge merges into this pulse.
            if (w_drain_fire) begin
                r_done_seen <= 1'b0;
            end else if (bus.done) begin
                r_done_seen <= 1'b1;
            end
            r_drain_done <= w_drain_fire;
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign bus.mem_wren = (r_state == ST_WRITE);
    assign drain_done   = r_drain_done;
    assign overflow     = r_overflow;
    assign pix_count    = r_pix_count;
    assign drop_count   = r_drop_count;
endmodule

// File: tb/tb_plot_stream_receiver.sv
// Directed bench for plot_stream_receiver: table of single beats plus multi-cycle
// sequences for rectangle drain, backpressure, saturation, reset and done merging.
module tb_plot_stream_receiver;
    localparam int ADDR_W = 15;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        drain_done;
    logic        overflow;
    logic [15:0] pix_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    plot_stream_receiver_if #(.ADDR_W(ADDR_W)) bus ();

    plot_stream_receiver #(
        .SCREEN_W   (160),
        .SCREEN_H   (120),
        .FIFO_DEPTH (8),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .drain_done (drain_done),
        .overflow   (overflow),
        .pix_count  (pix_count),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  color;
        logic        inRange;
        logic [14:0] addr;
    } vec_t;

    vec_t vecs [9];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    bit   monEnable = 1'b0;
    int   drainCount = 0;
    int   drainCycle = 0;
    int   wAddr [$];
    int   wData [$];
    int   wCycle [$];

    always @(posedge clk) cycle <= cycle + 1;

    // Passive monitor: logs accepted writes and drain pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (monEnable) begin
            if (bus.mem_wren && bus.mem_ack) begin
                wAddr.push_back(int'(bus.mem_addr));
                wData.push_back(int'(bus.mem_data));
                wCycle.push_back(cycle);
            end
            if (drain_done) begin
                drainCount++;
                drainCycle = cycle;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y,
                                 input logic [2:0] color, input logic plot, input logic done);
        bus.x     = x;
        bus.y     = y;
        bus.color = color;
        bus.plot  = plot;
        bus.done  = done;
        step();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearMon();
        wAddr.delete();
        wData.delete();
        wCycle.delete();
        drainCount = 0;
        drainCycle = 0;
    endtask

    task automatic doReset();
        bus.x = '0; bus.y = '0; bus.color = '0; bus.plot = 1'b0; bus.done = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (drainCount == 0 && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        int expPix;
        int expDrop;
        int doneCycle;

        vecs[0] = '{8'd5,   7'd2,   3'b011, 1'b1, 15'd325};
        vecs[1] = '{8'd160, 7'd0,   3'b001, 1'b0, 15'd0};
        vecs[2] = '{8'd0,   7'd120, 3'b010, 1'b0, 15'd0};
        vecs[3] = '{8'd159, 7'd119, 3'b110, 1'b1, 15'd19199};
        vecs[4] = '{8'd0,   7'd0,   3'b111, 1'b1, 15'd0};
        vecs[5] = '{8'd255, 7'd127, 3'b101, 1'b0, 15'd0};
        vecs[6] = '{8'd10,  7'd100, 3'b001, 1'b1, 15'd16010};
        vecs[7] = '{8'd159, 7'd0,   3'b010, 1'b1, 15'd159};
        vecs[8] = '{8'd0,   7'd119, 3'b100, 1'b1, 15'd19040};

        bus.x = '0; bus.y = '0; bus.color = '0; bus.plot = 1'b0; bus.done = 1'b0;
        bus.mem_ack = 1'b0;
        resetn = 1'b0;
        step(2);
        checkOutput("rst_wren", 32'(bus.mem_wren), 0);
        checkOutput("rst_addr", 32'(bus.mem_addr), 0);
        checkOutput("rst_data", 32'(bus.mem_data), 0);
        checkOutput("rst_drain", 32'(drain_done), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_pix", 32'(pix_count), 0);
        checkOutput("rst_drop", 32'(drop_count), 0);

        // Single beats with ack tied high: write appears one edge after sampling.
        resetn = 1'b1;
        bus.mem_ack = 1'b1;
        expPix = 0;
        expDrop = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].color, 1'b1, 1'b0);
            applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d_wren", i), 32'(bus.mem_wren), 32'(vecs[i].inRange));
            if (vecs[i].inRange) begin
                checkOutput($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].addr));
                checkOutput($sformatf("vec%0d_data", i), 32'(bus.mem_data), 32'(vecs[i].color));
                expPix++;
            end else begin
                expDrop++;
            end
            checkOutput($sformatf("vec%0d_drop", i), 32'(drop_count), 32'(expDrop));
            step();
            checkOutput($sformatf("vec%0d_wren_off", i), 32'(bus.mem_wren), 0);
            checkOutput($sformatf("vec%0d_pix", i), 32'(pix_count), 32'(expPix));
        end

        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'd200, 7'd10, 3'd1, 1'b1, 1'b0);
        end
        applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("drop_saturate", 32'(drop_count), 255);
        checkOutput("drop_no_write", 32'(bus.mem_wren), 0);
        checkOutput("drop_pix_kept", 32'(pix_count), 32'(expPix));

        // 11x10 rectangle in raster order, then done.
        doReset();
        bus.mem_ack = 1'b1;
        clearMon();
        monEnable = 1'b1;
        for (int yy = 0; yy < 10; yy++) begin
            for (int xx = 0; xx < 11; xx++) begin
                applyStimulus(8'(xx), 7'(yy), 3'b011, 1'b1, 1'b0);
            end
        end
        applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
        applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        waitDrain(50);
        step(3);
        monEnable = 1'b0;
        checkOutput("rect_writes", 32'(wAddr.size()), 110);
        for (int k = 0; k < wAddr.size() && k < 110; k++) begin
            checkOutput($sformatf("rect_addr%0d", k), 32'(wAddr[k]), 32'((k / 11) * 160 + (k % 11)));
            checkOutput($sformatf("rect_data%0d", k), 32'(wData[k]), 3);
        end
        checkOutput("rect_drain_pulses", 32'(drainCount), 1);
        checkOutput("rect_pix", 32'(pix_count), 110);
        checkOutput("rect_overflow", 32'(overflow), 0);

        // Backpressure: 12 beats with no ack, only 9 survive.
        doReset();
        bus.mem_ack = 1'b0;
        clearMon();
        monEnable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'(i), 7'd3, 3'(i), 1'b1, 1'b0);
        end
        applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        step(2);
        checkOutput("bp_overflow", 32'(overflow), 1);
        checkOutput("bp_wren_held", 32'(bus.mem_wren), 1);
        checkOutput("bp_addr_held", 32'(bus.mem_addr), 480);
        checkOutput("bp_no_early_write", 32'(wAddr.size()), 0);
        bus.mem_ack = 1'b1;
        step(15);
        monEnable = 1'b0;
        checkOutput("bp_writes", 32'(wAddr.size()), 9);
        for (int k = 0; k < wAddr.size() && k < 9; k++) begin
            checkOutput($sformatf("bp_addr%0d", k), 32'(wAddr[k]), 32'(480 + k));
            checkOutput($sformatf("bp_data%0d", k), 32'(wData[k]), 32'(k % 8));
        end
        checkOutput("bp_pix", 32'(pix_count), 9);
        checkOutput("bp_overflow_sticky", 32'(overflow), 1);

        // Reset in the middle of a held write with three entries queued.
        doReset();
        bus.mem_ack = 1'b0;
        applyStimulus(8'd170, 7'd0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(40 + i), 7'd7, 3'd5, 1'b1, 1'b0);
        end
        applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("mid_wren_before", 32'(bus.mem_wren), 1);
        checkOutput("mid_addr_before", 32'(bus.mem_addr), 1160);
        checkOutput("mid_drop_before", 32'(drop_count), 1);
        resetn = 1'b0;
        step();
        checkOutput("mid_wren_after", 32'(bus.mem_wren), 0);
        checkOutput("mid_addr_after", 32'(bus.mem_addr), 0);
        checkOutput("mid_data_after", 32'(bus.mem_data), 0);
        checkOutput("mid_drop_after", 32'(drop_count), 0);
        checkOutput("mid_pix_after", 32'(pix_count), 0);
        resetn = 1'b1;
        bus.mem_ack = 1'b1;
        clearMon();
        monEnable = 1'b1;
        step(10);
        monEnable = 1'b0;
        checkOutput("mid_no_writes", 32'(wAddr.size()), 0);

        // Done (twice, merged) with four writes pending and ack toggling.
        doReset();
        bus.mem_ack = 1'b0;
        clearMon();
        monEnable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(20 + i), 7'd5, 3'(i + 1), 1'b1, 1'b0);
        end
        applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
        applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        applyStimulus(8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
        bus.done = 1'b0;
        checkOutput("drain_not_early", 32'(drainCount), 0);
        for (int k = 0; k < 20; k++) begin
            bus.mem_ack = ((k % 2) == 0);
            step();
        end
        bus.mem_ack = 1'b0;
        step(2);
        monEnable = 1'b0;
        checkOutput("drain_writes", 32'(wAddr.size()), 4);
        checkOutput("drain_pulses", 32'(drainCount), 1);
        if (wCycle.size() == 4) begin
            checkOutput("drain_after_4th_ack", 32'(drainCycle), 32'(wCycle[3] + 1));
            checkOutput("drain_last_addr", 32'(wAddr[3]), 823);
        end

        // Done on an idle, empty receiver.
        clearMon();
        monEnable = 1'b1;
        doneCycle = cycle;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step(4);
        monEnable = 1'b0;
        checkOutput("idle_done_pulses", 32'(drainCount), 1);
        checkOutput("idle_done_latency", 32'(drainCycle), 32'(doneCycle + 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/plot_stream_receiver.md
Name: plot_stream_receiver

Overview:
- Receiving end of the pixel plot stream (x, y, color, plot, done) produced by the sprite draw/erase counters.
- Buffers incoming plot beats in a small FIFO, range-checks them, and converts each to a linear framebuffer address (y*SCREEN_W + x).
- Issues held write requests to the framebuffer memory port with a wren/ack handshake.
- Reports when a complete rectangle (terminated by the sender's done pulse) has been fully committed to memory.

Parameters:
- SCREEN_W, 160, visible width in pixels; x is valid when x < SCREEN_W.
- SCREEN_H, 120, visible height in pixels; y is valid when y < SCREEN_H.
- FIFO_DEPTH, 8, input FIFO entries; power of two, minimum 2.
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- x  input  8  pixel column from sender.
- y  input  7  pixel row from sender.
- color  input  3  pixel colour from sender.
- plot  input  1  beat valid; one pixel per cycle when high; no backpressure to sender.
- done  input  1  one-cycle pulse marking end of a rectangle.
- mem_addr  output  ADDR_W  framebuffer write address.
- mem_data  output  3  framebuffer write data.
- mem_wren  output  1  write request; held until acknowledged.
- mem_ack  input  1  memory accepts the write on a cycle where mem_wren=1.
- drain_done  output  1  one-cycle pulse: all pixels before done are committed.
- overflow  output  1  sticky: a valid beat was lost to a full FIFO.
- pix_count  output  16  count of acknowledged writes; wraps.
- drop_count  output  8  count of out-of-range beats; saturates at 255.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - mem_wren=0, mem_addr=0, mem_data=0, drain_done=0, overflow=0, pix_count=0, drop_count=0.
  - FIFO emptied and done_seen cleared.
  - Any pending write is abandoned, including mid-handshake.
- Input acceptance, on every cycle with plot=1:
  - Out of range (x >= SCREEN_W or y >= SCREEN_H): beat discarded; drop_count increments, saturating.
  - In range and FIFO not full: push {addr, color}. addr = y*SCREEN_W + x, computed at push in ADDR_W bits. The product cannot exceed the range because of the bounds check.
  - In range and FIFO full: push allowed only if a pop occurs in the same cycle. Otherwise the beat is lost and overflow is set, staying set until reset.
  - plot=0: no push; x, y and color are ignored.
- Write FSM, two states:
  - IDLE, mem_wren=0: if FIFO non-empty, load head into mem_addr/mem_data, pop, go to WRITE.
  - WRITE, mem_wren=1, mem_addr/mem_data stable while mem_ack=0.
  - In WRITE with mem_ack=1: pix_count+1. If FIFO non-empty, load the next head, pop, and stay in WRITE (back-to-back, 1 write/cycle). Otherwise go to IDLE.
  - mem_ack while in IDLE is ignored.
- Latency and capacity:
  - A beat sampled at edge E0 into an empty FIFO with FSM in IDLE gives mem_wren=1 after edge E1.
  - Effective buffering is FIFO_DEPTH + 1, counting the output register.
- Done handling:
  - done=1 sets done_seen. This is independent of plot, and a same-cycle plot beat is still processed.
  - drain_done pulses for one cycle after the first edge where done_seen=1, the FIFO is empty, and the FSM is in IDLE (including the edge that returns from WRITE). done_seen clears with that pulse.
  - A done arriving while done_seen is already set merges; it produces one pulse only.
  - A done on an idle, empty receiver gives drain_done=1 two edges after the done beat is sampled.
- Ordering: writes leave in exact arrival order; no reordering and no coalescing of repeated addresses.

Test Plan:
- Single pixel: reset, then x=5, y=2, color=3'b011, plot=1 for one cycle, mem_ack tied high -> mem_wren high for exactly one cycle, mem_addr=325, mem_data=3'b011, pix_count=1.
- Rectangle stream: 11x10 block from (0,0) with color 3'b011, then a done pulse, mem_ack tied high -> 110 writes in raster order, then drain_done pulses once; pix_count=110, overflow=0.
- Backpressure: mem_ack held 0 while 12 consecutive in-range beats arrive with FIFO_DEPTH=8 -> first 9 beats held (1 in output register, 8 in FIFO), overflow=1. After mem_ack=1, exactly 9 writes with the original data, in order.
- Range check: beats (160,0), (0,120), (159,119) -> drop_count=2, single write at addr 19199; a further 300 out-of-range beats leave drop_count=255.
- Reset mid-handshake: mem_wren=1 with mem_ack=0 and 3 entries queued, resetn=0 for one edge -> next cycle mem_wren=0, counters=0; no writes after release without new beats.
- Done while draining: done pulse arrives with 4 writes pending and mem_ack toggling 1/0 -> drain_done asserts only after the fourth ack, for exactly one cycle.
